// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter between the CPU and debug ports for the shared SRAM,
// sequencing fixed-latency read/write cycles and returning data with a one-cycle ack.
module sram_arbiter #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        busy,
    output logic        owner
);
    typedef enum logic [2:0] {IDLE, RD, WR, WHOLD, DONE} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        last_owner, grant_cpu, grant, win, win_we;
    logic [15:0] win_addr, win_wdata;
    // On a tie the port that did not own the bus last time wins.
    always_comb begin
        grant_cpu = cpu_req && (!dbg_req || last_owner);
        grant     = cpu_req || dbg_req;
        win       = !grant_cpu;
        win_we    = win ? dbg_we : cpu_we;
        win_addr  = win ? dbg_addr : cpu_addr;
        win_wdata = win ? dbg_wdata : cpu_wdata;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    owner      <= win;
                    last_owner <= win;
                    sram_addr  <= win_addr;
                    sram_wdata <= win_wdata;
                    cnt        <= win_we ? 4'(WR_WAIT) : 4'(RD_WAIT);
                    sram_we    <= win_we;
                    sram_oe    <= !win_we;
                    busy       <= 1'b1;
                    state      <= win_we ? WR : RD;
                end
                RD: if (cnt == 4'd0) begin
                    if (owner) dbg_rdata <= sram_rdata;
                    else cpu_rdata <= sram_rdata;
                    cpu_ack <= !owner;
                    dbg_ack <= owner;
                    sram_oe <= 1'b0;
                    state   <= DONE;
                end else cnt <= cnt - 4'd1;
                WR: if (cnt == 4'd0) begin
                    sram_we <= 1'b0;
                    state   <= WHOLD;
                end else cnt <= cnt - 4'd1;
                WHOLD: begin
                    cpu_ack <= !owner;
                    dbg_ack <= owner;
                    state   <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of arbitration, access timing, reset abort and
// zero-wait parameters; SRAM model reads back {addr[7:0], addr[7:0]} until written.
module tb_sram_arbiter;
    logic        Clk = 1'b0, Reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [15:0] cpu_rdata, dbg_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        cpu_ack, dbg_ack, sram_oe, sram_we, busy, owner;
    logic [15:0] cpu_rdata2, dbg_rdata2, sram_addr2, sram_wdata2;
    logic        cpu_ack2, dbg_ack2, sram_oe2, sram_we2, busy2, owner2;
    logic [15:0] sram_rdata2 = 16'h5A5A;
    logic [15:0] mem [256];
    logic [255:0] written = '0;
    int n_checks = 0, n_fail = 0;

    always #5 Clk = ~Clk;

    sram_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_oe(sram_oe), .sram_we(sram_we), .busy(busy), .owner(owner)
    );

    sram_arbiter #(.RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata2), .dbg_ack(dbg_ack2),
        .sram_addr(sram_addr2), .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata2),
        .sram_oe(sram_oe2), .sram_we(sram_we2), .busy(busy2), .owner(owner2)
    );

    assign sram_rdata = written[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {sram_addr[7:0], sram_addr[7:0]};
    always @(posedge Clk) if (sram_we) begin
        mem[sram_addr[7:0]] <= sram_wdata;
        written[sram_addr[7:0]] <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    // Starts in an IDLE cycle (c0); records oe/we per cycle k and the ack cycle.
    task automatic xact(input bit d2, input logic we, input logic [15:0] addr, wdata, addr_c1,
                        output int ack_at, output logic [12:0] oe_m, we_m,
                        output logic [15:0] rd, output int acks, output bit overlap);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        ack_at = 0; oe_m = '0; we_m = '0; rd = '0; acks = 0; overlap = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge Clk); #1;
            if (k == 1) cpu_addr = addr_c1;
            oe_m[k] = d2 ? sram_oe2 : sram_oe;
            we_m[k] = d2 ? sram_we2 : sram_we;
            if (oe_m[k] && we_m[k]) overlap = 1'b1;
            if (d2 ? cpu_ack2 : cpu_ack) begin
                acks++;
                if (ack_at == 0) begin
                    ack_at = k;
                    rd = d2 ? cpu_rdata2 : cpu_rdata;
                end
                cpu_req = 1'b0;
            end
        end
    endtask

    initial begin
        int ack_at, acks, n;
        logic [12:0] oe_m, we_m;
        logic [15:0] rd;
        logic [3:0] seq, own;
        bit overlap, flag, both;
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_oe_we", {sram_oe, sram_we}, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        check("rst_acks", {cpu_ack, dbg_ack}, 0);
        flag = 1'b0;
        repeat (10) begin @(posedge Clk); #1; if (busy) flag = 1'b1; end
        check("idle_busy", flag, 0);

        // Reset during c2 of a read aborts it; cpu_rdata keeps its prior value (0).
        cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_req = 1'b1;
        @(posedge Clk); #1;
        check("abort_c1_oe", sram_oe, 1);
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0; cpu_req = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_oe", sram_oe, 0);
        flag = 1'b0;
        repeat (6) begin if (cpu_ack) flag = 1'b1; @(posedge Clk); #1; end
        check("abort_no_ack", flag, 0);
        check("abort_rdata", cpu_rdata, 0);

        xact(0, 1, 16'h0010, 16'hBEEF, 16'h0010, ack_at, oe_m, we_m, rd, acks, overlap);
        check("wr_ack_cycle", ack_at, 4);
        check("wr_we_mask", we_m, 13'h006);
        check("wr_oe_mask", oe_m, 0);
        check("wr_ack_count", acks, 1);
        check("wr_mem", mem[8'h10], 16'hBEEF);
        xact(0, 0, 16'h0010, 16'h0, 16'h0010, ack_at, oe_m, we_m, rd, acks, overlap);
        check("rd_ack_cycle", ack_at, 4);
        check("rd_oe_mask", oe_m, 13'h00E);
        check("rd_we_mask", we_m, 0);
        check("rd_data", rd, 16'hBEEF);

        xact(0, 0, 16'h0020, 16'h0, 16'h0030, ack_at, oe_m, we_m, rd, acks, overlap);
        check("chg_rdata", rd, 16'h2020);
        check("chg_addr_held", sram_addr, 16'h0020);

        // Both ports request continuously: strict alternation starting with the CPU.
        do_reset();
        cpu_we = 1'b0; cpu_addr = 16'h0010; dbg_we = 1'b0; dbg_addr = 16'h0044;
        cpu_req = 1'b1; dbg_req = 1'b1;
        n = 0; seq = '0; own = '0; both = 1'b0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(posedge Clk); #1;
            if (cpu_ack && dbg_ack) both = 1'b1;
            if (cpu_ack || dbg_ack) begin
                seq[n] = dbg_ack;
                own[n] = owner;
                if (n == 0) check("tie_dbg_rdata_a0", dbg_rdata, 0);
                if (n == 2) check("tie_dbg_rdata_a2", dbg_rdata, 16'h4444);
                n++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) @(posedge Clk); #1;
        check("tie_count", n, 4);
        check("tie_grants", seq, 4'b1010);
        check("tie_owner", own, 4'b1010);
        check("tie_no_dual_ack", both, 0);
        check("tie_cpu_rdata", cpu_rdata, 16'hBEEF);
        check("tie_dbg_rdata", dbg_rdata, 16'h4444);

        do_reset();
        xact(1, 0, 16'h0050, 16'h0, 16'h0050, ack_at, oe_m, we_m, rd, acks, overlap);
        check("w0_rd_ack_cycle", ack_at, 2);
        check("w0_rd_oe_mask", oe_m, 13'h002);
        check("w0_rd_data", rd, 16'h5A5A);
        check("w0_rd_overlap", overlap, 0);
        xact(1, 1, 16'h0050, 16'h7777, 16'h0050, ack_at, oe_m, we_m, rd, acks, overlap);
        check("w0_wr_ack_cycle", ack_at, 3);
        check("w0_wr_we_mask", we_m, 13'h002);
        check("w0_wr_overlap", overlap, 0);
        check("w0_wr_ack_count", acks, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
